ysyx_idu_iq: RTL and testbench
==============================

Name: ysyx_idu_iq

Overview:
- Decode-side instruction queue with operand-readiness check. Sits between the IFU and the decoder/EXU issue point.
- Buffers up to DEPTH fetched {pc, inst} pairs and reads register operands for the head entry.
- Resolves operands from NFWD forwarding channels with priority, or from the register file.
- Stalls the head only when a source register is actually used, is pending in the scoreboard, and is not forwarded.
- Output is raw pc/inst plus resolved operand values; ysyx_idu_decoder is instantiated downstream.

Parameters:
- XLEN, `YSYX_XLEN: data/pc width.
- REG_LEN, `YSYX_REG_LEN: register index width (4 = RV32E, 5 = RV32I).
- REG_NUM, `YSYX_REG_NUM: scoreboard width, equal to 2**REG_LEN.
- DEPTH, 4: queue entries, power of two, ≥2.
- NFWD, 2: number of forwarding channels; channel 0 has highest priority.

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush  in  1  discard all queued entries (redirect)
- in_valid  in  1  fetch entry offered
- in_ready  out  1  queue can accept
- in_pc  in  XLEN  fetched pc
- in_inst  in  32  fetched instruction
- out_rs1  out  REG_LEN  head inst[15+:REG_LEN], to regfile read port 1
- out_rs2  out  REG_LEN  head inst[20+:REG_LEN], to regfile read port 2
- rdata1  in  XLEN  combinational regfile value for out_rs1
- rdata2  in  XLEN  combinational regfile value for out_rs2
- rf_table  in  REG_NUM  scoreboard; bit i set means x[i] has a write in flight
- fwd_valid  in  NFWD  forwarding channel valid
- fwd_rd  in  NFWD*REG_LEN  destination per channel, channel k at [k*REG_LEN +: REG_LEN]
- fwd_data  in  NFWD*XLEN  result per channel
- out_valid  out  1  head issuable
- out_ready  in  1  consumer accepts
- out_pc  out  XLEN  head pc
- out_inst  out  32  head instruction
- out_rs1v  out  XLEN  resolved rs1 value
- out_rs2v  out  XLEN  resolved rs2 value
- count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset:
  - Pointers and count are 0.
  - out_valid=0; in_ready=1 once reset deasserts.
  - Stored pc/inst are don't-care, but out_inst reads 0 when the queue is empty.
- Push: in_valid && in_ready writes the tail entry, and the tail pointer advances modulo DEPTH.
- in_ready = (count != DEPTH) && !flush.
  - A full queue does not accept a push even when it pops in the same cycle.
- Pop: out_valid && out_ready advances the head pointer.
- Simultaneous push and pop: count is unchanged.
- Source usage, decoded from head opcode inst[6:0]:
  - uses_rs1 is false for LUI, AUIPC, JAL, and SYSTEM with func3[2]=1 (CSR immediate forms); true otherwise.
  - uses_rs2 is true only for OP (0110011), STORE (0100011) and BRANCH (1100011).
- Forward hit for rsN:
  - Some channel k has fwd_valid[k] and fwd_rd[k]==rsN, with rsN != 0.
  - When several channels hit, the lowest k wins.
- Operand value for rsN:
  - rsN==0 gives 0.
  - Otherwise a forward hit gives fwd_data[k], even if the rf_table bit is clear.
  - Otherwise rdataN.
- hazard_N = uses_rsN && rsN!=0 && rf_table[rsN] && !forward_hit_N.
- out_valid = (count != 0) && !hazard_1 && !hazard_2 && !flush.
  - Outputs are combinational from the head entry and the inputs.
  - A new entry is visible at the earliest one cycle after its push (latency 1).
- Flush:
  - In the flush cycle, out_valid=0 and in_ready=0; push and pop are both ignored.
  - On the next edge, count=0 and pointers=0.
  - Reset dominates flush.
- Pointer wrap: head and tail wrap from DEPTH-1 to 0; full and empty are distinguished by count.
- REG_LEN=4: index fields take the low 4 bits; inst bits 19 and 24 are ignored.

Optional Feature:
- Macro: YSYX_IDU_IQ_BYPASS_EN
- Defined:
  - When count==0, in_valid is high and flush is low, the incoming pc/inst drive the head path in the same cycle.
  - Operand resolution and the hazard check apply to it.
  - If it is issued (out_valid && out_ready), it is not written into the queue.
  - Zero-latency issue.
- Not defined: no bypass; minimum latency 1 cycle.

Test Plan:
- Push 4 ALU instructions, out_ready=0 → count=4, in_ready=0. Then out_ready=1 for 4 cycles → pcs issue in order 0x80000000, 0x80000004, 0x80000008, 0x8000000c; count returns to 0.
- Head `add x5,x6,x7` with rf_table[7]=1 and no forward → out_valid=0. Set fwd_valid[1]=1, fwd_rd[1]=7, fwd_data[1]=0x1234 → out_valid=1, out_rs2v=0x1234.
- Head `lui x5,0x1` with rf_table=all ones → out_valid=1 (no source used). Head `addi x1,x0,1` → out_rs1v=0, no stall.
- Channels 0 and 1 both valid with rd=3, data 0xA and 0xB, head `addi x4,x3,0` → out_rs1v=0xA.
- Queue holding 3 entries, flush pulsed with in_valid=1 → out_valid=0 and in_ready=0 that cycle; count=0 next cycle; the offered entry is not stored.
- Fill to full (DEPTH=4), then push and pop alternately for 10 cycles → no loss or duplication across pointer wrap. With the macro defined and the queue empty, an issuable push gives out_valid=1 in the same cycle and count stays 0.

Source files
------------

// File: rtl/ysyx_idu_iq.sv
// Decode-side instruction queue: buffers {pc, inst}, resolves head operands via forwarding/regfile
// and holds the head on a true RAW hazard. Optional same-cycle bypass: YSYX_IDU_IQ_BYPASS_EN.
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif
`ifndef YSYX_REG_LEN
`define YSYX_REG_LEN 5
`endif
`ifndef YSYX_REG_NUM
`define YSYX_REG_NUM 32
`endif

module ysyx_idu_iq #(
  parameter int XLEN    = `YSYX_XLEN,
  parameter int REG_LEN = `YSYX_REG_LEN,
  parameter int REG_NUM = `YSYX_REG_NUM,
  parameter int DEPTH   = 4,
  parameter int NFWD    = 2
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [XLEN-1:0]           in_pc,
  input  logic [31:0]               in_inst,
  output logic [REG_LEN-1:0]        out_rs1,
  output logic [REG_LEN-1:0]        out_rs2,
  input  logic [XLEN-1:0]           rdata1,
  input  logic [XLEN-1:0]           rdata2,
  input  logic [REG_NUM-1:0]        rf_table,
  input  logic [NFWD-1:0]           fwd_valid,
  input  logic [NFWD*REG_LEN-1:0]   fwd_rd,
  input  logic [NFWD*XLEN-1:0]      fwd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_inst,
  output logic [XLEN-1:0]           out_rs1v,
  output logic [XLEN-1:0]           out_rs2v,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0]    pc_mem_r   [DEPTH];
  logic [31:0]        inst_mem_r [DEPTH];
  logic [PW-1:0]      head_r, tail_r;
  logic [CW-1:0]      count_r;
  logic               bypass_s, empty_s, head_valid_s, fire_s, push_s, pop_s;
  logic [XLEN-1:0]    head_pc_s;
  logic [31:0]        head_inst_s;
  logic [REG_LEN-1:0] rs1_s, rs2_s;
  logic               hit1_s, hit2_s, use1_s, use2_s, haz1_s, haz2_s;
  logic [XLEN-1:0]    fwd1_s, fwd2_s;

  // LUI, AUIPC, JAL and CSR-immediate SYSTEM forms carry no rs1 operand.
  function automatic logic uses_rs1_f(input logic [6:0] op, input logic f3_msb);
    logic u;
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111: u = 1'b0;
      7'b1110011:                         u = ~f3_msb;
      default:                            u = 1'b1;
    endcase
    return u;
  endfunction

  function automatic logic uses_rs2_f(input logic [6:0] op);
    logic u;
    case (op)
      7'b0110011, 7'b0100011, 7'b1100011: u = 1'b1;
      default:                            u = 1'b0;
    endcase
    return u;
  endfunction

  assign empty_s = (count_r == {CW{1'b0}});
`ifdef YSYX_IDU_IQ_BYPASS_EN
  assign bypass_s = empty_s && in_valid && !flush;
`else
  assign bypass_s = 1'b0;
`endif

  // Head selection: bypassed fetch entry, stored entry, or zero instruction when empty.
  always_comb begin
    head_pc_s   = pc_mem_r[head_r];
    head_inst_s = 32'd0;
    if (bypass_s) begin
      head_pc_s   = in_pc;
      head_inst_s = in_inst;
    end else if (!empty_s) begin
      head_inst_s = inst_mem_r[head_r];
    end else begin
      head_inst_s = 32'd0;
    end
  end

  assign rs1_s  = head_inst_s[15 +: REG_LEN];
  assign rs2_s  = head_inst_s[20 +: REG_LEN];
  assign use1_s = uses_rs1_f(head_inst_s[6:0], head_inst_s[14]);
  assign use2_s = uses_rs2_f(head_inst_s[6:0]);

  // Forward match; scanning downward lets the lowest-numbered channel win.
  always_comb begin
    hit1_s = 1'b0;
    hit2_s = 1'b0;
    fwd1_s = {XLEN{1'b0}};
    fwd2_s = {XLEN{1'b0}};
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (fwd_valid[k] && (fwd_rd[k*REG_LEN +: REG_LEN] == rs1_s) && (rs1_s != {REG_LEN{1'b0}})) begin
        hit1_s = 1'b1;
        fwd1_s = fwd_data[k*XLEN +: XLEN];
      end else begin
        hit1_s = hit1_s;
      end
      if (fwd_valid[k] && (fwd_rd[k*REG_LEN +: REG_LEN] == rs2_s) && (rs2_s != {REG_LEN{1'b0}})) begin
        hit2_s = 1'b1;
        fwd2_s = fwd_data[k*XLEN +: XLEN];
      end else begin
        hit2_s = hit2_s;
      end
    end
  end

  assign haz1_s = use1_s && (rs1_s != {REG_LEN{1'b0}}) && rf_table[rs1_s] && !hit1_s;
  assign haz2_s = use2_s && (rs2_s != {REG_LEN{1'b0}}) && rf_table[rs2_s] && !hit2_s;

  assign head_valid_s = !empty_s || bypass_s;
  assign out_valid    = head_valid_s && !haz1_s && !haz2_s && !flush;
  assign in_ready     = (count_r != CW'(DEPTH)) && !flush;
  assign fire_s       = out_valid && out_ready;
  // A bypassed entry that issues never occupies a slot.
  assign push_s       = in_valid && in_ready && !(bypass_s && fire_s);
  assign pop_s        = fire_s && !bypass_s;

  assign out_rs1  = rs1_s;
  assign out_rs2  = rs2_s;
  assign out_pc   = head_pc_s;
  assign out_inst = head_inst_s;
  assign out_rs1v = (rs1_s == {REG_LEN{1'b0}}) ? {XLEN{1'b0}} : (hit1_s ? fwd1_s : rdata1);
  assign out_rs2v = (rs2_s == {REG_LEN{1'b0}}) ? {XLEN{1'b0}} : (hit2_s ? fwd2_s : rdata2);
  assign count    = count_r;

  // Queue storage; contents are don't-care until the pointers say otherwise.
  always_ff @(posedge clock) begin
    if (push_s) begin
      pc_mem_r[tail_r]   <= in_pc;
      inst_mem_r[tail_r] <= in_inst;
    end
  end

  // Pointers and occupancy; reset dominates flush.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      head_r  <= {PW{1'b0}};
      tail_r  <= {PW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (push_s) tail_r <= tail_r + PW'(1);
      if (pop_s)  head_r <= head_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_idu_iq.sv
// Directed bench for ysyx_idu_iq: ordering, hazards, forwarding priority, flush and pointer wrap.
module tb_ysyx_idu_iq;
  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, rdata1, rdata2, out_pc, out_inst, out_rs1v, out_rs2v;
  logic [4:0]  out_rs1, out_rs2;
  logic [31:0] rf_table;
  logic [1:0]  fwd_valid;
  logic [9:0]  fwd_rd;
  logic [63:0] fwd_data;
  logic [2:0]  count;
  int compared = 0;
  int mismatched = 0;
  int push_n, pop_n;

  localparam logic [31:0] ADD_567  = 32'h007302B3; // add  x5,x6,x7
  localparam logic [31:0] LUI_5    = 32'h123452B7; // lui  x5,0x12345 (rs fields nonzero)
  localparam logic [31:0] ADDI_101 = 32'h00100093; // addi x1,x0,1
  localparam logic [31:0] ADDI_430 = 32'h00018213; // addi x4,x3,0

  ysyx_idu_iq #(.XLEN(32), .REG_LEN(5), .REG_NUM(32), .DEPTH(4), .NFWD(2)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .rdata1(rdata1), .rdata2(rdata2), .rf_table(rf_table), .fwd_valid(fwd_valid),
    .fwd_rd(fwd_rd), .fwd_data(fwd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_rs1v(out_rs1v), .out_rs2v(out_rs2v), .count(count)
  );

  always #5 clock = ~clock;

  // Register file stand-in: x[i] reads 0x1000+i on port 1 and 0x2000+i on port 2.
  assign rdata1 = 32'h0000_1000 + {27'd0, out_rs1};
  assign rdata2 = 32'h0000_2000 + {27'd0, out_rs2};

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'd0; in_inst = 32'd0; rf_table = 32'd0;
    fwd_valid = 2'b00; fwd_rd = 10'd0; fwd_data = 64'd0;
    step; step;
    reset = 1'b0;
    #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_inst", 64'(out_inst), 64'd0);

    // Fill with four ALU ops while the consumer stalls.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'h8000_0000 + 32'(4 * i); in_inst = ADDI_101;
      step;
    end
    in_valid = 1'b0;
    #1;
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_in_ready", 64'(in_ready), 64'd0);
    // Drain in order; first drain cycle also offers a push that a full queue must refuse.
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'b1;
      in_valid = (i == 0); in_pc = 32'h9000_0000;
      #1;
      chk("drain_pc", 64'(out_pc), 64'(32'h8000_0000 + 32'(4 * i)));
      chk("drain_count", 64'(count), 64'(4 - i));
      step;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("drain_empty", 64'(count), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // RAW hazard on rs2, then released by forwarding channel 1.
    rf_table = 32'h0000_0080;
    in_valid = 1'b1; in_pc = 32'h8000_0010; in_inst = ADD_567;
    step;
    in_valid = 1'b0;
    #1;
    chk("haz_stall", 64'(out_valid), 64'd0);
    chk("haz_rs2_idx", 64'(out_rs2), 64'd7);
    fwd_valid = 2'b10; fwd_rd = {5'd7, 5'd0}; fwd_data = {32'h0000_1234, 32'h0};
    #1;
    chk("fwd_release", 64'(out_valid), 64'd1);
    chk("fwd_rs2v", 64'(out_rs2v), 64'h1234);
    chk("rf_rs1v", 64'(out_rs1v), 64'h1006);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0; fwd_valid = 2'b00;

    // Unused sources never stall: LUI and ADDI with every scoreboard bit set.
    rf_table = 32'hFFFF_FFFF;
    in_valid = 1'b1; in_pc = 32'h8000_0020; in_inst = LUI_5;
    step;
    in_pc = 32'h8000_0024; in_inst = ADDI_101;
    step;
    in_valid = 1'b0;
    #1;
    chk("lui_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    #1;
    chk("addi_x0_valid", 64'(out_valid), 64'd1);
    chk("addi_x0_rs1v", 64'(out_rs1v), 64'd0);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0; rf_table = 32'd0;

    // Forwarding priority: channel 0 beats channel 1.
    in_valid = 1'b1; in_pc = 32'h8000_0030; in_inst = ADDI_430;
    step;
    in_valid = 1'b0;
    fwd_valid = 2'b11; fwd_rd = {5'd3, 5'd3}; fwd_data = {32'h0000_000B, 32'h0000_000A};
    #1;
    chk("prio_both", 64'(out_rs1v), 64'hA);
    fwd_valid = 2'b10;
    #1;
    chk("prio_ch1", 64'(out_rs1v), 64'hB);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0; fwd_valid = 2'b00;

    // Flush with three entries queued and a fetch offered.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h8000_0040 + 32'(4 * i); in_inst = ADDI_101;
      step;
    end
    flush = 1'b1; in_pc = 32'h8000_0050;
    #1;
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready", 64'(in_ready), 64'd0);
    step;
    flush = 1'b0; in_valid = 1'b0;
    #1;
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_not_stored", 64'(out_inst), 64'd0);

    // Fill, then alternate pop/push across the pointer wrap.
    push_n = 0; pop_n = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 32'hA000_0000 + 32'(4 * push_n); in_inst = ADDI_101;
      push_n++;
      step;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) begin
        out_ready = 1'b1; in_valid = 1'b0;
        #1;
        chk("wrap_pop_pc", 64'(out_pc), 64'(32'hA000_0000 + 32'(4 * pop_n)));
        pop_n++;
      end else begin
        out_ready = 1'b0; in_valid = 1'b1;
        in_pc = 32'hA000_0000 + 32'(4 * push_n);
        push_n++;
      end
      step;
    end
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("wrap_full", 64'(count), 64'd4);
    chk("wrap_pop_pc", 64'(out_pc), 64'(32'hA000_0000 + 32'(4 * pop_n)));
    pop_n++;
    step;
    // Simultaneous push and pop below full keeps occupancy.
    in_valid = 1'b1; in_pc = 32'hA000_0000 + 32'(4 * push_n); push_n++;
    #1;
    chk("simul_pc", 64'(out_pc), 64'(32'hA000_0000 + 32'(4 * pop_n)));
    pop_n++;
    step;
    in_valid = 1'b0;
    #1;
    chk("simul_count", 64'(count), 64'd3);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("wrap_tail_pc", 64'(out_pc), 64'(32'hA000_0000 + 32'(4 * pop_n)));
      pop_n++;
      step;
    end
    #1;
    chk("wrap_total", 64'(pop_n), 64'(push_n));
    chk("wrap_empty", 64'(count), 64'd0);

    // Push into an empty queue with the consumer ready.
    in_valid = 1'b1; in_pc = 32'hB000_0000; in_inst = ADDI_101; out_ready = 1'b1;
    #1;
`ifdef YSYX_IDU_IQ_BYPASS_EN
    chk("bypass_valid", 64'(out_valid), 64'd1);
    chk("bypass_pc", 64'(out_pc), 64'hB000_0000);
    step;
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("bypass_count", 64'(count), 64'd0);
`else
    chk("latency_valid", 64'(out_valid), 64'd0);
    step;
    in_valid = 1'b0;
    #1;
    chk("latency_count", 64'(count), 64'd1);
    chk("latency_pc", 64'(out_pc), 64'hB000_0000);
    step;
    out_ready = 1'b0;
    #1;
    chk("latency_drain", 64'(count), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
